idma_stream_id_tracker: RTL and testbench

Per-stream transfer-ID generator and completion tracker for the iDMA register front-end path. Sits between the register front-end arbiter and a single in-order back-end. Forwards 1D requests unchanged, supplies the `next_id` the front-end returns to software on launch, and counts back-end completions into per-stream `done_id` values and busy flags.

---
 rtl/idma_stream_id_tracker.sv | 160 ++++++++++++++++
 tb/tb_idma_stream_id_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/idma_stream_id_tracker.sv
// Per-stream transfer-ID generator and completion tracker.
// Requests pass straight through to one in-order back-end. An order FIFO
// remembers which stream each accepted request belongs to, so every
// back-end completion can be credited to the right stream.

// One stream's counters: next ID to hand out, last completed ID, and the
// number of transfers in flight.
module idma_stream_id_ctr #(
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned OutCntWidth    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      acc,
  input  logic                      cpl,
  output logic [IdCounterWidth-1:0] next_cnt,
  output logic [IdCounterWidth-1:0] done_cnt,
  output logic                      busy
);

  logic [OutCntWidth-1:0] out_cnt;

  // IDs wrap from all-ones to 1; 0 is reserved for "nothing completed".
  function automatic logic [IdCounterWidth-1:0] id_adv(input logic [IdCounterWidth-1:0] id);
    logic [IdCounterWidth-1:0] n;
    n = id + IdCounterWidth'(1);
    return (n == '0) ? IdCounterWidth'(1) : n;
  endfunction

  // Advance ID counters and track outstanding transfers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_cnt <= IdCounterWidth'(1);
      done_cnt <= '0;
      out_cnt  <= '0;
    end else begin
      if (acc) next_cnt <= id_adv(next_cnt);
      if (cpl) done_cnt <= id_adv(done_cnt);
      case ({acc, cpl})
        2'b10:   out_cnt <= out_cnt + OutCntWidth'(1);
        2'b01:   out_cnt <= out_cnt - OutCntWidth'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign busy = (out_cnt != '0);

endmodule

module idma_stream_id_tracker #(
  parameter int unsigned NumStreams     = 1,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1,
  parameter type         dma_req_t      = logic
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  dma_req_t                                   req_i,
  input  logic                                       req_valid_i,
  output logic                                       req_ready_o,
  input  logic [StreamWidth-1:0]                     stream_idx_i,
  output logic [IdCounterWidth-1:0]                  next_id_o,
  output logic [NumStreams-1:0][IdCounterWidth-1:0]  done_id_o,
  output logic [NumStreams-1:0]                      busy_o,
  output dma_req_t                                   be_req_o,
  output logic                                       be_req_valid_o,
  input  logic                                       be_req_ready_i,
  input  logic                                       be_rsp_valid_i,
  output logic                                       be_rsp_ready_o
);

  localparam int unsigned PtrW     = $clog2(MaxOutstanding);
  localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
  localparam int unsigned NumSlots = 2 ** StreamWidth;

  logic [StreamWidth-1:0] fifo_mem [MaxOutstanding];
  logic [PtrW-1:0]        wr_ptr, rd_ptr;
  logic [CntW-1:0]        fifo_cnt;
  logic                   fifo_full, fifo_empty;
  logic [StreamWidth-1:0] head;
  logic                   accept, pop;
  logic [NumSlots-1:0]    stream_exists;
  logic                   stream_ok;
  logic [NumStreams-1:0]  acc_vec, cpl_vec;
  logic [NumStreams-1:0][IdCounterWidth-1:0] next_cnt;

  // Constant mask of index values that name a real stream.
  for (genvar s = 0; s < NumSlots; s++) begin : g_exists
    assign stream_exists[s] = (s < NumStreams);
  end
  assign stream_ok = stream_exists[stream_idx_i];

  assign fifo_full  = (fifo_cnt == CntW'(MaxOutstanding));
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_mem[rd_ptr];

  // Out-of-range streams are neither forwarded nor acknowledged.
  assign be_req_o       = req_i;
  assign be_req_valid_o = req_valid_i && !fifo_full && stream_ok;
  assign req_ready_o    = be_req_ready_i && !fifo_full && stream_ok;
  assign be_rsp_ready_o = 1'b1;

  assign accept = req_valid_i && req_ready_o;
  assign pop    = be_rsp_valid_i && !fifo_empty;

  // Order FIFO pointers and fill level; stray completions are flagged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)    rd_ptr <= rd_ptr + PtrW'(1);
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      assert (!(be_rsp_valid_i && fifo_empty))
        else $warning("completion received with no outstanding transfer");
      assert (!(req_valid_i && !stream_ok))
        else $warning("request offered on nonexistent stream %0d", stream_idx_i);
    end
  end

  // Order FIFO storage; contents are only read when the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr] <= stream_idx_i;
  end

  // Per-stream counter instances.
  for (genvar i = 0; i < NumStreams; i++) begin : g_stream
    assign acc_vec[i] = accept && (stream_idx_i == StreamWidth'(i));
    assign cpl_vec[i] = pop && (head == StreamWidth'(i));

    idma_stream_id_ctr #(
      .IdCounterWidth (IdCounterWidth),
      .OutCntWidth    (CntW)
    ) u_ctr (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .acc      (acc_vec[i]),
      .cpl      (cpl_vec[i]),
      .next_cnt (next_cnt[i]),
      .done_cnt (done_id_o[i]),
      .busy     (busy_o[i])
    );
  end

  // ID offered to the currently presented request.
  always_comb begin
    next_id_o = '0;
    for (int i = 0; i < NumStreams; i++)
      if (stream_idx_i == StreamWidth'(i)) next_id_o = next_cnt[i];
  end

endmodule

// File: tb/tb_idma_stream_id_tracker.sv
// Directed bench for idma_stream_id_tracker: 4 streams, 4-bit IDs, depth 8.
module tb_idma_stream_id_tracker;

  logic             clk, rst_n;
  logic [7:0]       req, be_req;
  logic             req_valid, req_ready;
  logic [1:0]       stream;
  logic [3:0]       next_id;
  logic [3:0][3:0]  done_id;
  logic [3:0]       busy;
  logic             be_valid, be_ready, rsp_valid, rsp_ready;

  int n_chk = 0;
  int n_err = 0;

  idma_stream_id_tracker #(
    .NumStreams     (4),
    .IdCounterWidth (4),
    .MaxOutstanding (8),
    .dma_req_t      (logic [7:0])
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .stream_idx_i   (stream),
    .next_id_o      (next_id),
    .done_id_o      (done_id),
    .busy_o         (busy),
    .be_req_o       (be_req),
    .be_req_valid_o (be_valid),
    .be_req_ready_i (be_ready),
    .be_rsp_valid_i (rsp_valid),
    .be_rsp_ready_o (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 0; rsp_valid = 0; be_ready = 1; stream = 0;
    #1 rst_n = 0;
    #2 rst_n = 1;
    #1;
  endtask

  initial begin
    rst_n = 0; req = 8'h00; req_valid = 0; stream = 0; be_ready = 1; rsp_valid = 0;

    // Reset state
    #7;
    chk("rst_busy",    32'(busy), 0);
    chk("rst_done",    32'(done_id), 0);
    chk("rst_next",    32'(next_id), 1);
    chk("rst_ready",   32'(req_ready), 1);
    chk("rst_bevalid", 32'(be_valid), 0);
    chk("rst_rsprdy",  32'(rsp_ready), 1);
    rst_n = 1;
    cyc();

    // Single accept / completion on stream 0
    req = 8'hA5; stream = 0; req_valid = 1;
    #1;
    chk("t1_next0",   32'(next_id), 1);
    chk("t1_bevalid", 32'(be_valid), 1);
    chk("t1_bereq",   32'(be_req), 32'hA5);
    cyc();
    req_valid = 0;
    #1;
    chk("t1_next1", 32'(next_id), 2);
    chk("t1_busy1", 32'(busy), 4'b0001);
    chk("t1_done0", 32'(done_id[0]), 0);
    rsp_valid = 1;
    cyc();
    rsp_valid = 0;
    chk("t1_done1", 32'(done_id[0]), 1);
    chk("t1_busy0", 32'(busy), 0);

    // Interleaved streams 2,0,2
    do_reset();
    stream = 2; req_valid = 1; #1 chk("t2_id_a", 32'(next_id), 1); cyc();
    stream = 0;                #1 chk("t2_id_b", 32'(next_id), 1); cyc();
    stream = 2;                #1 chk("t2_id_c", 32'(next_id), 2); cyc();
    req_valid = 0;
    chk("t2_busy", 32'(busy), 4'b0101);
    rsp_valid = 1; cyc(); rsp_valid = 0;
    chk("t2_c1_done2", 32'(done_id[2]), 1);
    chk("t2_c1_busy",  32'(busy), 4'b0101);
    rsp_valid = 1; cyc(); rsp_valid = 0;
    chk("t2_c2_done0", 32'(done_id[0]), 1);
    chk("t2_c2_busy",  32'(busy), 4'b0100);
    rsp_valid = 1; cyc(); rsp_valid = 0;
    chk("t2_c3_done2", 32'(done_id[2]), 2);
    chk("t2_c3_busy",  32'(busy), 0);

    // FIFO full and no fall-through
    do_reset();
    stream = 3; req_valid = 1;
    repeat (8) cyc();
    chk("t3_full_ready",   32'(req_ready), 0);
    chk("t3_full_bevalid", 32'(be_valid), 0);
    chk("t3_full_next",    32'(next_id), 9);
    chk("t3_full_busy",    32'(busy), 4'b1000);
    cyc();
    chk("t3_hold_next", 32'(next_id), 9);
    rsp_valid = 1;
    #1 chk("t3_pop_ready", 32'(req_ready), 0);
    cyc();
    rsp_valid = 0;
    #1;
    chk("t3_after_ready", 32'(req_ready), 1);
    chk("t3_after_done",  32'(done_id[3]), 1);
    chk("t3_after_next",  32'(next_id), 9);
    cyc();
    req_valid = 0;
    #1;
    chk("t3_acc_next",  32'(next_id), 10);
    chk("t3_acc_ready", 32'(req_ready), 0);
    rsp_valid = 1;
    repeat (8) cyc();
    rsp_valid = 0;
    #1;
    chk("t3_drain_done",  32'(done_id[3]), 9);
    chk("t3_drain_busy",  32'(busy), 0);
    chk("t3_drain_ready", 32'(req_ready), 1);

    // ID wrap with 4-bit counters on stream 1
    do_reset();
    stream = 1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_id;
      exp_id = 4'((i % 15) + 1);
      req_valid = 1;
      #1 chk($sformatf("t4_next_%0d", i), 32'(next_id), 32'(exp_id));
      cyc();
      req_valid = 0; rsp_valid = 1;
      cyc();
      rsp_valid = 0;
      chk($sformatf("t4_done_%0d", i), 32'(done_id[1]), 32'(exp_id));
    end
    // Accept and complete in the same cycle on the same stream
    req_valid = 1; cyc(); req_valid = 0;
    chk("t4_sc_next0", 32'(next_id), 3);
    chk("t4_sc_busy0", 32'(busy), 4'b0010);
    req_valid = 1; rsp_valid = 1; cyc(); req_valid = 0; rsp_valid = 0;
    #1;
    chk("t4_sc_next1", 32'(next_id), 4);
    chk("t4_sc_done1", 32'(done_id[1]), 2);
    chk("t4_sc_busy1", 32'(busy), 4'b0010);
    rsp_valid = 1; cyc(); rsp_valid = 0;
    chk("t4_sc_done2", 32'(done_id[1]), 3);
    chk("t4_sc_busy2", 32'(busy), 0);

    // Back-end stall
    do_reset();
    be_ready = 0; stream = 2; req = 8'h3C; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t5_next_%0d", i),  32'(next_id), 1);
      chk($sformatf("t5_ready_%0d", i), 32'(req_ready), 0);
      chk($sformatf("t5_bereq_%0d", i), 32'(be_req), 32'h3C);
      chk($sformatf("t5_bev_%0d", i),   32'(be_valid), 1);
    end
    req_valid = 0; be_ready = 1;
    #1 chk("t5_busy", 32'(busy), 0);

    // Asynchronous reset with transfers outstanding
    do_reset();
    stream = 0; req_valid = 1;
    repeat (3) cyc();
    req_valid = 0;
    #1;
    chk("t6_pre_busy", 32'(busy), 4'b0001);
    chk("t6_pre_next", 32'(next_id), 4);
    rst_n = 0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_next", 32'(next_id), 1);
    chk("t6_rst_done", 32'(done_id), 0);
    #1 rst_n = 1;
    rsp_valid = 1;
    cyc();
    rsp_valid = 0;
    #1;
    chk("t6_stray_done",  32'(done_id), 0);
    chk("t6_stray_busy",  32'(busy), 0);
    chk("t6_stray_next",  32'(next_id), 1);
    chk("t6_stray_ready", 32'(req_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
